// File: rtl/and_nxw_pipe.sv
// Registered N-lane, W-bit bitwise combiner (AND/OR/XOR/PASS) behind a valid/ready output stage.
// Define AND_NXW_PIPE_ACCUM_EN to fold consecutive beats into one result per LAST-terminated frame.
module and_nxw_pipe #(
    parameter int N  = 2,
    parameter int W  = 2,
    parameter int CW = 8
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic [N*W-1:0]  I,
    input  logic [1:0]      OP,
    input  logic            LAST,
    input  logic            I_VALID,
    output logic            I_READY,
    output logic [W-1:0]    O,
    output logic [CW-1:0]   O_COUNT,
    output logic            O_VALID,
    input  logic            O_READY
);

    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_PASS} op_t;

    // Handshake: a beat moves when I_VALID && I_READY; a result moves when O_VALID && O_READY.
    // I_READY depends only on the output stage, never on I_VALID.
    function automatic logic [W-1:0] combine(op_t op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = a;
        endcase
        return y;
    endfunction

    logic         accept;
    op_t          beat_op;
    logic [W-1:0] r;

    assign I_READY = !O_VALID || O_READY;
    assign accept  = I_VALID && I_READY;

    // PASS leaves lane 0 in r because combine() returns its left operand.
    always_comb begin
        r = I[W-1:0];
        for (int k = 1; k < N; k++) begin
            r = combine(beat_op, r, I[k*W +: W]);
        end
    end

`ifdef AND_NXW_PIPE_ACCUM_EN
    logic          in_frame;
    op_t           frame_op;
    logic [W-1:0]  acc;
    logic [W-1:0]  fold;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // The operation is latched on the first beat of a frame and used for every later beat.
    assign beat_op = in_frame ? frame_op : op_t'(OP);

    // First beat: identity op r == r, so the identity constant never needs materialising.
    always_comb begin
        fold     = r;
        cnt_next = CW'(1);
        if (in_frame) begin
            fold     = (beat_op == OP_PASS) ? r : combine(beat_op, acc, r);
            cnt_next = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            O        <= '0;
            O_COUNT  <= '0;
            O_VALID  <= 1'b0;
            in_frame <= 1'b0;
            frame_op <= OP_AND;
            acc      <= '0;
            cnt      <= '0;
        end else if (accept && LAST) begin
            O        <= fold;
            O_COUNT  <= cnt_next;
            O_VALID  <= 1'b1;
            in_frame <= 1'b0;
        end else begin
            if (O_READY) begin
                O_VALID <= 1'b0;
            end
            if (accept) begin
                acc      <= fold;
                cnt      <= cnt_next;
                in_frame <= 1'b1;
                if (!in_frame) begin
                    frame_op <= beat_op;
                end
            end
        end
    end
`else
    logic unused_last;

    assign unused_last = LAST;
    assign beat_op     = op_t'(OP);
    assign O_COUNT     = '0;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            O       <= '0;
            O_VALID <= 1'b0;
        end else if (accept) begin
            O       <= r;
            O_VALID <= 1'b1;
        end else if (O_READY) begin
            O_VALID <= 1'b0;
        end
    end
`endif

endmodule
